// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async_fifo1 write port between NREQ producers.
// Each grant covers a burst of up to BURST_LEN words and stalls while wfull is high.
module fifo_write_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  output logic                  busy
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int PW = $clog2(NREQ);

  typedef enum logic {IDLE, BURST} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [PW-1:0]   g_idx;
  logic [PW-1:0]   pick_idx;
  logic            pick_vld;
  logic [PW-1:0]   next_ptr;
  logic            xfer;
  logic            burst_done;
  logic            withdraw;
  logic            rel;

  // NOTE: every variable gets a default before the loop, so no latch can be inferred.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) g_idx = PW'(i);
    end
  end

  // First requester at or after rr_ptr, searching upward with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(rr_ptr_q) + k) % NREQ;
      if (!pick_vld && req[j]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(j);
      end
    end
  end

  assign next_ptr   = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;
  assign xfer       = !wrst && (state_q == BURST) && req[g_idx] && !wfull;
  assign burst_done = xfer && (req_last[g_idx] || (cnt_q == CW'(BURST_LEN - 1)));
  assign withdraw   = (state_q == BURST) && !req[g_idx];
  assign rel        = burst_done || withdraw;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BURST;
          grant_d = '0;
          grant_d[pick_idx] = 1'b1;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (rel) begin
          state_d  = IDLE;
          grant_d  = '0;
          cnt_d    = '0;
          rr_ptr_d = next_ptr;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == BURST);
  assign winc  = xfer;
  assign ack   = grant_q & {NREQ{xfer}};
  assign wdata = req_data[int'(g_idx)*DSIZE +: DSIZE];

  grant_onehot_a: assert property (@(posedge wclk) disable iff (wrst) $onehot0(grant_q));

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: producer queues drive the DUT, a negedge
// monitor checks grants/writes against an abstract arbitration model and per-requester queues.
module tb_fifo_write_arbiter;

  localparam int DSIZE     = 8;
  localparam int NREQ      = 4;
  localparam int BURST_LEN = 16;

  logic                  wclk = 1'b0;
  logic                  wrst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull = 1'b0;
  logic                  busy;

  fifo_write_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST_LEN(BURST_LEN)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .req_last(req_last),
    .grant(grant), .ack(ack), .winc(winc), .wdata(wdata), .wfull(wfull), .busy(busy)
  );

  always #5 wclk = ~wclk;

  typedef struct {logic [DSIZE-1:0] data; logic last;} word_t;
  typedef struct {int owner; int len;} burst_t;

  word_t            pq[NREQ][$];   // words each producer still has to offer
  logic [DSIZE-1:0] sb[NREQ][$];   // words expected to reach the FIFO, per requester
  burst_t           blog[$];       // completed bursts as seen by the model
  logic [NREQ-1:0]  en = '0;

  int tests = 0;
  int fails = 0;
  int act_wr = 0;
  bit mon_on = 1'b0;

  int m_owner = -1;
  int m_words = 0;
  int m_ptr   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input int i, input logic [DSIZE-1:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    pq[i].push_back(w);
    sb[i].push_back(d);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && pq[i].size() > 0) begin
        req[i] = 1'b1;
        req_data[i*DSIZE +: DSIZE] = pq[i][0].data;
        req_last[i] = pq[i][0].last;
      end else begin
        req[i] = 1'b0;
        req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
  endtask

  // One clock: sample acks mid-cycle, then retire acked words and present new ones.
  task automatic step();
    logic [NREQ-1:0] a;
    @(negedge wclk);
    a = ack;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (a[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    end
    drive();
  endtask

  task automatic do_reset();
    en = '0;
    drive();
    wrst = 1'b1;
    step();
    wrst = 1'b0;
    blog.delete();
    act_wr = 0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c = 0;
    while (act_wr < n && c < budget) begin
      step();
      c++;
    end
    if (act_wr < n) check("wait_writes_timeout", act_wr, n);
  endtask

  task automatic drain(input int budget);
    int  c = 0;
    bit  done = 1'b0;
    wfull = 1'b0;
    drive();
    while (!done && c < budget) begin
      step();
      c++;
      done = (m_owner < 0);
      for (int i = 0; i < NREQ; i++) if (en[i] && pq[i].size() > 0) done = 1'b0;
    end
    if (!done) check("drain_timeout", 32'(c), 32'(budget + 1));
  endtask

  task automatic check_burst(input int k, input int owner, input int len);
    if (k >= blog.size()) begin
      check("burst_missing", blog.size(), k + 1);
    end else begin
      check($sformatf("burst%0d_owner", k), blog[k].owner, owner);
      check($sformatf("burst%0d_len", k), blog[k].len, len);
    end
  endtask

  // Monitor: compare the DUT with the arbitration rules, then advance the model
  // to the state that should exist after the coming rising edge.
  always @(negedge wclk) begin : monitor
    logic [NREQ-1:0] exp_grant;
    logic            exp_x;
    bit              found;
    int              j;
    if (winc === 1'b1) act_wr++;
    if (mon_on) begin
      exp_grant = '0;
      if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
      exp_x = !wrst && (m_owner >= 0) && req[m_owner] && !wfull;
      check("grant", 32'(grant), 32'(exp_grant));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("winc", 32'(winc), 32'(exp_x));
      check("ack", 32'(ack), 32'(exp_grant & {NREQ{exp_x}}));
      if (exp_x && winc === 1'b1) begin
        if (sb[m_owner].size() == 0) check("sb_empty", 32'(wdata), 32'hFFFF_FFFF);
        else check("wdata", 32'(wdata), 32'(sb[m_owner].pop_front()));
      end
      if (wrst) begin
        m_owner = -1;
        m_words = 0;
        m_ptr   = 0;
      end else if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (!found && req[j]) begin
            found   = 1'b1;
            m_owner = j;
            m_words = 0;
          end
        end
      end else if (!req[m_owner]) begin
        blog.push_back('{m_owner, m_words});
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else if (exp_x) begin
        m_words++;
        if (req_last[m_owner] || m_words == BURST_LEN) begin
          blog.push_back('{m_owner, m_words});
          m_ptr   = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end
    end
  end

  initial begin
    step();
    wrst = 1'b0;
    mon_on = 1'b1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // Single requester 2: 40 words give bursts of 16, 16, then 8 ending on withdrawal.
    do_reset();
    for (int n = 0; n < 40; n++) push_word(2, DSIZE'($urandom), 1'b0);
    en = 4'b0100;
    drive();
    drain(200);
    check_burst(0, 2, 16);
    check_burst(1, 2, 16);
    check_burst(2, 2, 8);

    // All four continuously requesting: strict 0,1,2,3 rotation, full bursts.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 2 * BURST_LEN; n++) push_word(i, DSIZE'($urandom), 1'b0);
    en = '1;
    drive();
    drain(400);
    for (int k = 0; k < 8; k++) check_burst(k, k % NREQ, BURST_LEN);
    check("rotation_count", blog.size(), 8);

    // Early end: requester 1 ends on word 5, so 2 beats 0 for the next grant.
    do_reset();
    for (int n = 0; n < 5; n++) push_word(1, DSIZE'($urandom), n == 4);
    en = 4'b0010;
    drive();
    step();
    for (int n = 0; n < 3; n++) push_word(0, DSIZE'($urandom), n == 2);
    for (int n = 0; n < 3; n++) push_word(2, DSIZE'($urandom), n == 2);
    en = 4'b0111;
    drive();
    drain(100);
    check_burst(0, 1, 5);
    check_burst(1, 2, 3);
    check_burst(2, 0, 3);

    // Backpressure after word 3: seven stalled cycles, burst still totals 16.
    do_reset();
    for (int n = 0; n < BURST_LEN; n++) push_word(0, DSIZE'($urandom), 1'b0);
    en = 4'b0001;
    drive();
    wait_writes(3, 20);
    wfull = 1'b1;
    for (int n = 0; n < 7; n++) step();
    check("stall_writes", act_wr, 3);
    check("stall_grant", 32'(grant), 32'h1);
    drain(100);
    check("bp_total", act_wr, BURST_LEN);
    check_burst(0, 0, BURST_LEN);
    check("bp_bursts", blog.size(), 1);

    // Withdrawal of requester 3 after 2 words, then it comes back for the rest.
    do_reset();
    for (int n = 0; n < 10; n++) push_word(3, DSIZE'($urandom), 1'b0);
    en = 4'b1000;
    drive();
    wait_writes(2, 20);
    en = 4'b0000;
    drive();
    step();
    step();
    check("withdraw_writes", act_wr, 2);
    check_burst(0, 3, 2);
    en = 4'b1000;
    drain(100);
    check_burst(1, 3, 8);

    // Reset mid-burst: no write in the reset cycle, arbitration restarts at 0.
    do_reset();
    for (int n = 0; n < 10; n++) push_word(1, DSIZE'($urandom), 1'b0);
    en = 4'b0010;
    drive();
    wait_writes(3, 20);
    for (int n = 0; n < 4; n++) push_word(0, DSIZE'($urandom), 1'b0);
    en = 4'b0011;
    wrst = 1'b1;
    drive();
    step();
    wrst = 1'b0;
    check("rst_writes", act_wr, 3);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    drain(100);
    check_burst(0, 0, 4);
    check_burst(1, 1, 7);

    // Randomized traffic: random data, burst ends, backpressure and withdrawals.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 60; n++) push_word(i, DSIZE'($urandom), $urandom_range(0, 7) == 0);
    en = '1;
    drive();
    for (int c = 0; c < 1500; c++) begin
      step();
      wfull = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) en[$urandom_range(0, NREQ - 1)] ^= 1'b1;
      drive();
    end
    en = '1;
    drain(2000);
    for (int i = 0; i < NREQ; i++) check($sformatf("sb%0d_left", i), sb[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that shares the single write port of `async_fifo1` between `NREQ` producers in the write clock domain. It grants one requester at a time for a burst of up to `BURST_LEN` words and drives `winc`/`wdata` directly into the FIFO. While `wfull` is high it stalls the granted requester without losing or duplicating data. It sits between the producer blocks and the FIFO write side, replacing direct producer-to-FIFO wiring.

## Interface
- `DSIZE`, 8: data word width; matches `async_fifo1` DSIZE.
- `NREQ`, 4: number of requesters, 2..16.
- `BURST_LEN`, 16: maximum words per grant, ≥1.

- `wclk`  in  1  write-domain clock; all logic on its rising edge.
- `wrst`  in  1  reset. One clock; reset is synchronous and active-high.
- `req`  in  NREQ  per-requester "word valid / want port"; requester i holds `req[i]` and its data until `ack[i]`.
- `req_data`  in  NREQ*DSIZE  word of requester i at bits [i*DSIZE +: DSIZE].
- `req_last`  in  NREQ  qualifies the current word of requester i as the final word of its burst.
- `grant`  out  NREQ  one-hot registered grant; all-zero when idle.
- `ack`  out  NREQ  word of requester i is written this cycle.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DSIZE  FIFO write data.
- `wfull`  in  1  FIFO full flag, from `async_fifo1`.
- `busy`  out  1  a grant is active (state BURST).

## Operation
- States:
  - IDLE: `grant`=0. If any `req` bit is set, select the first set bit at or after `rr_ptr`, searching in ascending index with wrap. Register that one-hot value into `grant` and go to BURST.
  - BURST: requester g = `grant` index.
- Transfer condition: `xfer` = BURST && `req[g]` && !`wfull`. Combinational outputs:
  - `winc` = `xfer`
  - `ack` = `grant` & {NREQ{`xfer`}}
  - `wdata` = `req_data` slice g (don't-care when `winc`=0; drive slice g)
- Word counter `cnt`, width $clog2(BURST_LEN)+1:
  - Cleared on entering BURST.
  - Increments on each `xfer`.
- Release BURST → IDLE at the end of the cycle in which any of the following holds:
  - (a) `xfer` && `req_last[g]`
  - (b) `xfer` && `cnt` == BURST_LEN-1
  - (c) !`req[g]`: requester withdrew; no word is written in that cycle.
  - If (a) and (b) coincide, the result is a single release.
- On release, `rr_ptr` = (g+1) mod NREQ.
- `wfull` high in BURST: no `xfer`, `cnt` holds, grant holds; this does not count as a release.
- `busy` = (state == BURST).
- Non-granted requesters never see `ack`. Their `req` and data are ignored until granted.
- `req_last` is only sampled on `xfer` cycles.

## Timing
- Reset (`wrst`=1 at a rising edge):
  - state=IDLE, `grant`=0, `cnt`=0, `rr_ptr`=0, `busy`=0.
  - `winc`=0 and `ack`=0 are forced combinationally while `wrst`=1.
  - Reset mid-burst aborts the burst; no write occurs in the reset cycle.
- Grant latency: `req[i]` rises in cycle 0 with the arbiter idle → `grant[i]`=1 and `busy`=1 in cycle 1. The first `winc` occurs in cycle 1 if `wfull`=0.
- Throughput:
  - One word per cycle within a burst while `wfull`=0.
  - Exactly one idle (arbitration) cycle between consecutive bursts.
  - Peak port utilisation is BURST_LEN/(BURST_LEN+1).
- `wfull` is used in the same cycle it is sampled (combinational into `winc`). The FIFO guarantees `wfull` is already registered in `wclk`.
- Fairness: with all requesters continuously requesting, the grant order is 0,1,...,NREQ-1,0,... Each gets BURST_LEN words per round.
- BURST_LEN=1: every accepted word releases the grant.

## Test plan
- Single requester: NREQ=4, BURST_LEN=16, `req[2]`=1 continuously, `wfull`=0 → `grant`=4'b0100 for 16 cycles with 16 `winc` pulses. Then 1 idle cycle, then a re-grant to 2. FIFO contents match the pushed sequence in order.
- All four requesting continuously → grant order 0,1,2,3,0. Each burst is exactly 16 words, with a one-cycle gap between bursts.
- Early end: requester 1 asserts `req_last` on its 5th word → release after 5 writes. `rr_ptr`=2, and requester 2 is granted next even though 0 is also requesting.
- Backpressure: `wfull` forced high for 7 cycles mid-burst after word 3 → no `winc`/`ack` during those cycles. `cnt` holds at 3, and the burst completes with exactly 16 words total and no duplicates.
- Withdrawal and reset:
  - Requester 3 drops `req` after 2 words → release with no write in the drop cycle.
  - `wrst` pulsed mid-burst → `winc`=0 in that cycle, `grant`=0 and `busy`=0 afterwards. The next grant starts from requester 0.
- End-to-end: two requesters each push 512 `$urandom` words into `async_fifo1` (wclk 240 MHz, rclk 400 MHz). A per-requester tagged scoreboard checks the read-side order for every burst.
